// File: rtl/alu_top.sv
// 4-bit, 16-operation ALU with a registered 8-bit result.
// Operands and opcode are sampled every rising edge; the result appears one cycle later.
module alu_top (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] r1,
    input  logic [3:0] r2,
    input  logic [3:0] op_code,
    output logic [7:0] out
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_MUL  = 4'b0010,
        OP_DIV  = 4'b0011,
        OP_AND  = 4'b0100,
        OP_OR   = 4'b0101,
        OP_XOR  = 4'b0110,
        OP_NAND = 4'b0111,
        OP_SHL  = 4'b1000,
        OP_SHR  = 4'b1001,
        OP_ROL  = 4'b1010,
        OP_ROR  = 4'b1011,
        OP_CMP  = 4'b1100,
        OP_CAT  = 4'b1101,
        OP_ABS  = 4'b1110,
        OP_HOLD = 4'b1111
    } op_t;

    logic [7:0] out_reg;
    logic [7:0] result_next;

    logic [7:0] a_ext;
    logic [7:0] b_ext;
    logic [3:0] and_bits;
    logic [3:0] or_bits;
    logic [3:0] xor_bits;
    logic [7:0] rol_dbl;
    logic [7:0] ror_dbl;
    logic [3:0] quo;
    logic [3:0] rem;

    assign a_ext = {4'h0, r1};
    assign b_ext = {4'h0, r2};

    // Bitwise operations built per bit; NAND is the inverted AND bus.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bitwise
            assign and_bits[gi] = r1[gi] & r2[gi];
            assign or_bits[gi]  = r1[gi] | r2[gi];
            assign xor_bits[gi] = r1[gi] ^ r2[gi];
        end
    endgenerate

    // Rotating a doubled copy keeps the wrapped bits in the selected nibble.
    assign rol_dbl = {r1, r1} << r2[1:0];
    assign ror_dbl = {r1, r1} >> r2[1:0];

    // Divider outputs are only used when r2 is non-zero.
    assign quo = (r2 == 4'h0) ? 4'h0 : r1 / r2;
    assign rem = (r2 == 4'h0) ? 4'h0 : r1 % r2;

    always_comb begin
        result_next = out_reg;
        case (op_t'(op_code))
            OP_ADD:  result_next = a_ext + b_ext;
            OP_SUB:  result_next = a_ext - b_ext;
            OP_MUL:  result_next = a_ext * b_ext;
            OP_DIV:  result_next = (r2 == 4'h0) ? 8'hFF : {rem, quo};
            OP_AND:  result_next = {4'h0, and_bits};
            OP_OR:   result_next = {4'h0, or_bits};
            OP_XOR:  result_next = {4'h0, xor_bits};
            OP_NAND: result_next = {4'h0, ~and_bits};
            OP_SHL:  result_next = a_ext << r2;
            OP_SHR:  result_next = a_ext >> r2;
            OP_ROL:  result_next = {4'h0, rol_dbl[7:4]};
            OP_ROR:  result_next = {4'h0, ror_dbl[3:0]};
            OP_CMP:  result_next = {5'b0, (r1 > r2), (r1 == r2), (r1 < r2)};
            OP_CAT:  result_next = {r1, r2};
            OP_ABS:  result_next = (r1 >= r2) ? (a_ext - b_ext) : (b_ext - a_ext);
            OP_HOLD: result_next = out_reg;
            default: result_next = out_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_reg <= 8'h00;
        end else begin
            out_reg <= result_next;
        end
    end

    assign out = out_reg;

endmodule

// File: tb/tb_alu_top.sv
// Self-checking bench for alu_top: directed cases with known answers, then random
// operations compared against an arithmetic reference model.
module tb_alu_top;

    logic       clk;
    logic       rst_n;
    logic [3:0] r1;
    logic [3:0] r2;
    logic [3:0] op_code;
    logic [7:0] out;

    int n_checks;
    int n_pass;
    logic [7:0] model_out;

    alu_top dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .r1      (r1),
        .r2      (r2),
        .op_code (op_code),
        .out     (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference computed from the operation definitions with integer arithmetic.
    function automatic logic [7:0] ref_alu(input int a, input int b, input int op,
                                           input logic [7:0] prev);
        int res;
        int rot;
        res = 0;
        case (op)
            0:  res = (a + b) % 256;
            1:  res = (a - b + 256) % 256;
            2:  res = a * b;
            3:  res = (b == 0) ? 255 : (a % b) * 16 + (a / b);
            4:  res = a & b;
            5:  res = a | b;
            6:  res = a ^ b;
            7:  res = 15 - (a & b);
            8:  res = (b >= 8) ? 0 : (a * (2 ** b)) % 256;
            9:  res = (b >= 4) ? 0 : a / (2 ** b);
            10: begin
                rot = a;
                for (int k = 0; k < b % 4; k++) rot = (rot * 2) % 16 + rot / 8;
                res = rot;
            end
            11: begin
                rot = a;
                for (int k = 0; k < b % 4; k++) rot = rot / 2 + (rot % 2) * 8;
                res = rot;
            end
            12: res = (a > b) ? 4 : ((a == b) ? 2 : 1);
            13: res = a * 16 + b;
            14: res = (a > b) ? a - b : b - a;
            default: res = prev;
        endcase
        return res[7:0];
    endfunction

    task automatic step(input logic rst, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] op, input logic [7:0] want, input string tag);
        @(negedge clk);
        rst_n   = rst;
        r1      = a;
        r2      = b;
        op_code = op;
        @(posedge clk);
        #1;
        n_checks++;
        assert (out === want) n_pass++;
        else $error("FAIL %s: rst_n=%0b op=%h r1=%h r2=%h out=%h expected=%h",
                    tag, rst, op, a, b, out, want);
        $display("step %-10s rst_n=%0b op=%h r1=%h r2=%h out=%h expected=%h",
                 tag, rst, op, a, b, out, want);
        model_out = want;
    endtask

    initial begin
        logic       rr;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [3:0] rop;
        logic [7:0] w;

        n_checks  = 0;
        n_pass    = 0;
        model_out = 8'h00;
        rst_n     = 1'b0;
        r1        = 4'h0;
        r2        = 4'h0;
        op_code   = 4'h0;

        step(1'b0, 4'h5, 4'h3, 4'h0, 8'h00, "reset0");
        step(1'b0, 4'h5, 4'h3, 4'h2, 8'h00, "reset1");
        for (int i = 0; i < 3; i++) step(1'b1, 4'h0, 4'h0, 4'hF, 8'h00, "hold");

        step(1'b1, 4'h7, 4'h4, 4'h0, 8'h0B, "add");
        step(1'b1, 4'hA, 4'h1, 4'h1, 8'h09, "sub");
        step(1'b1, 4'h1, 4'h2, 4'h1, 8'hFF, "sub_wrap");
        step(1'b1, 4'hF, 4'hF, 4'hF, 8'hFF, "hold_ff");
        step(1'b1, 4'hF, 4'hF, 4'h2, 8'hE1, "mul_max");
        step(1'b1, 4'hF, 4'hF, 4'h0, 8'h1E, "add_max");
        step(1'b1, 4'hD, 4'h4, 4'h3, 8'h13, "div");
        step(1'b1, 4'h9, 4'h0, 4'h3, 8'hFF, "div_zero");
        step(1'b1, 4'hC, 4'hA, 4'h4, 8'h08, "and");
        step(1'b1, 4'hC, 4'hA, 4'h5, 8'h0E, "or");
        step(1'b1, 4'hC, 4'hA, 4'h6, 8'h06, "xor");
        step(1'b1, 4'hC, 4'hA, 4'h7, 8'h07, "nand");
        step(1'b1, 4'hF, 4'h3, 4'h8, 8'h78, "shl");
        step(1'b1, 4'hF, 4'h8, 4'h8, 8'h00, "shl_big");
        step(1'b1, 4'h8, 4'h5, 4'h9, 8'h00, "shr_big");
        step(1'b1, 4'h8, 4'h2, 4'h9, 8'h02, "shr");
        step(1'b1, 4'h9, 4'h1, 4'hA, 8'h03, "rol");
        step(1'b1, 4'h9, 4'h1, 4'hB, 8'h0C, "ror");
        step(1'b1, 4'h9, 4'h6, 4'hA, 8'h06, "rol_mod4");
        step(1'b1, 4'h5, 4'h9, 4'hC, 8'h01, "cmp_lt");
        step(1'b1, 4'h9, 4'h9, 4'hC, 8'h02, "cmp_eq");
        step(1'b1, 4'h9, 4'h5, 4'hC, 8'h04, "cmp_gt");
        step(1'b1, 4'hA, 4'h5, 4'hD, 8'hA5, "cat");
        step(1'b1, 4'h3, 4'hC, 4'hE, 8'h09, "absdiff");
        step(1'b0, 4'h7, 4'h4, 4'h0, 8'h00, "rst_prio");
        step(1'b1, 4'h7, 4'h4, 4'h0, 8'h0B, "post_rst");

        for (int i = 0; i < 300; i++) begin
            rr  = ($urandom_range(0, 19) != 0);
            ra  = 4'($urandom_range(0, 15));
            rb  = 4'($urandom_range(0, 15));
            rop = 4'($urandom_range(0, 15));
            w   = rr ? ref_alu(int'(ra), int'(rb), int'(rop), model_out) : 8'h00;
            step(rr, ra, rb, rop, w, "random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_top.md
Name: alu_top

Overview:
- 4-bit, 16-operation arithmetic/logic unit with a registered 8-bit result.
- Two 4-bit operands and a 4-bit opcode are sampled every rising clock edge; the result appears on `out` one cycle later.
- Used as a small datapath-level compute block; the top-level integration wrapper for operand/opcode fabric.

Parameters:
- None; all widths are fixed (operands 4 bits, opcode 4 bits, result 8 bits).

Ports:
- clk  input  1  system clock, all state updates on the rising edge
- rst_n  input  1  synchronous active-low reset
- r1  input  4  operand A, unsigned
- r2  input  4  operand B, unsigned
- op_code  input  4  operation select
- out  output  8  registered result

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low.
- Reset: when rst_n=0 at a rising edge, out <= 8'h00. Reset has priority over every opcode.
- Otherwise, at each rising edge, out <= f(op_code, r1, r2). Latency is exactly 1 cycle; there is no handshake; new operands are accepted every cycle.
- Inputs are used only at the edge; combinational glitches have no effect.
- Operands are unsigned and zero-extended to 8 bits unless stated otherwise. All arithmetic wraps modulo 256.
- 0000 ADD: r1+r2 (max 30, no wrap). Example: 7+4 = 8'h0B.
- 0001 SUB: r1-r2 mod 256. Example: 10-1 = 8'h09; 1-2 = 8'hFF.
- 0010 MUL: r1*r2, full 8-bit product (max 225 = 8'hE1).
- 0011 DIV: out[7:4] = r1 % r2, out[3:0] = r1 / r2. If r2=0, out = 8'hFF.
- 0100 AND, 0101 OR, 0110 XOR, 0111 NAND: computed as 4-bit bitwise results. out = {4'h0, result}.
- 1000 SHL: ({4'h0,r1} << r2) truncated to 8 bits. Shift amounts >= 8 give 0.
- 1001 SHR: {4'h0,r1} >> r2. Shift amounts >= 4 give 0.
- 1010 ROL: r1 rotated left by r2[1:0] within 4 bits. out = {4'h0, rot}.
- 1011 ROR: r1 rotated right by r2[1:0] within 4 bits. out = {4'h0, rot}.
- 1100 CMP: out = {5'b0, gt, eq, lt}, unsigned compare of r1 vs r2. Exactly one of the three bits is set.
- 1101 CAT: out = {r1, r2}.
- 1110 ABSDIFF: |r1 - r2|, range 0..15, zero-extended.
- 1111 HOLD: out keeps its previous value. After reset with op_code=1111, out stays 8'h00.
- No X propagation from opcode decode: every opcode value is defined. An implementation with a default branch must still match the table above.
- A reset asserted mid-stream clears out on that edge. The first edge after reset release computes normally from the current inputs.

Test Plan:
- Reset and hold: rst_n=0 for 2 cycles, then op_code=1111, r1=0, r2=0 -> out=8'h00 after reset and stays 8'h00 for 3 cycles.
- ADD then SUB back-to-back: cycle N r1=0111, r2=0100, op=0000 -> out=8'h0B at N+1. Cycle N+1 r1=1010, r2=0001, op=0001 -> out=8'h09 at N+2.
- Wrap and multiply: SUB r1=1, r2=2 -> 8'hFF. MUL r1=15, r2=15 -> 8'hE1. ADD r1=15, r2=15 -> 8'h1E.
- Divide: r1=13, r2=4 -> 8'h13 (rem 1, quo 3). r1=9, r2=0 -> 8'hFF.
- Logic, shift and rotate: AND 1100&1010 -> 8'h08. NAND 1100,1010 -> 8'h07. SHL r1=1111, r2=3 -> 8'h78. SHR r1=1000, r2=5 -> 8'h00. ROL r1=1001, r2=1 -> 8'h03. ROR r1=1001, r2=1 -> 8'h0C.
- Compare, concatenate and reset priority: CMP 5 vs 9 -> 8'h01; 9 vs 9 -> 8'h02; 9 vs 5 -> 8'h04. CAT r1=A, r2=5 -> 8'hA5. ABSDIFF 3, 12 -> 8'h09. Asserting rst_n=0 while op=0000, r1=7, r2=4 -> out=8'h00 on that edge.
